adder_share_arb: RTL and testbench

ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

---
 rtl/adder_share_arb.sv | 175 +++++++++++++++++
 tb/tb_adder_share_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// Purpose: two requesters share one registered carry-select adder through an IDLE/EXEC/DONE FSM with a fair tie-break.
// Latency: the accept edge loads the operand registers; the next edge (EXEC) loads the result and raises res_valid.
// Backpressure: one request in flight; readys stay low until the result is taken with res_valid & res_ready.
//
// Ports:
//   clk, rst_n                  : single clock, synchronous active-low reset
//   reqN_valid/_a/_b/_cin/_ready: requester N add request and handshake (N = 0, 1)
//   res_valid/_sum/_cout/_id    : registered result, carry-out and owning requester
//   res_ready                   : consumer accepts the result
//   busy                        : FSM is not in IDLE
module adder_share_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NBLK = (WIDTH + 3) / 4;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic             op_id_q, op_id_d;
    logic             last_grant_q, last_grant_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             res_id_q, res_id_d;

    logic             gnt_vld;
    logic             gnt_id;
    logic             accept;

    // Carry-select adder on the operand registers: each 4-bit block
    // precomputes both carry-in cases and the incoming carry picks one.
    // The top block is narrower when WIDTH is not a multiple of 4.
    logic [NBLK:0]    blk_c;
    logic [WIDTH-1:0] add_sum;

    assign blk_c[0] = op_cin_q;

    genvar g;
    generate
        for (g = 0; g < NBLK; g++) begin : g_csel
            localparam int LO = 4 * g;
            localparam int BW = ((WIDTH - LO) < 4) ? (WIDTH - LO) : 4;
            logic [BW:0] s0;
            logic [BW:0] s1;
            assign s0 = {1'b0, op_a_q[LO +: BW]} + {1'b0, op_b_q[LO +: BW]};
            assign s1 = {1'b0, op_a_q[LO +: BW]} + {1'b0, op_b_q[LO +: BW]} + {{BW{1'b0}}, 1'b1};
            assign add_sum[LO +: BW] = blk_c[g] ? s1[BW-1:0] : s0[BW-1:0];
            assign blk_c[g+1]        = blk_c[g] ? s1[BW]     : s0[BW];
        end
    endgenerate

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = ~last_grant_q;
        end else if (req0_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end else if (req1_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    // rst_n gates ready so nothing appears accepted while reset is held.
    assign accept     = rst_n && (state_q == IDLE) && gnt_vld;
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept && gnt_id;

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_cin_d     = op_cin_q;
        op_id_d      = op_id_q;
        last_grant_d = last_grant_q;
        res_valid_d  = res_valid_q;
        res_sum_d    = res_sum_q;
        res_cout_d   = res_cout_q;
        res_id_d     = res_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d       = gnt_id ? req1_a   : req0_a;
                    op_b_d       = gnt_id ? req1_b   : req0_b;
                    op_cin_d     = gnt_id ? req1_cin : req0_cin;
                    op_id_d      = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                res_sum_d   = add_sum;
                res_cout_d  = blk_c[NBLK];
                res_id_d    = op_id_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // Returning to IDLE here means the next grant is only
                // evaluated one cycle later, never on the release edge.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_cin_q     <= 1'b0;
            op_id_q      <= 1'b0;
            last_grant_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_sum_q    <= '0;
            res_cout_q   <= 1'b0;
            res_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_cin_q     <= op_cin_d;
            op_id_q      <= op_id_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_sum_q    <= res_sum_d;
            res_cout_q   <= res_cout_d;
            res_id_q     <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Purpose: directed self-checking bench for adder_share_arb (WIDTH = 8).
// Latency: inputs driven and outputs sampled 1 ns after each rising edge.
// Backpressure: exercises res_ready held low in DONE and requests arriving while busy.
module tb_adder_share_arb;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_cin, req0_ready;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_cin, req1_ready;
    logic [7:0] req1_a, req1_b;
    logic       res_valid, res_cout, res_id, res_ready, busy;
    logic [7:0] res_sum;

    int n_checks = 0;
    int n_fail   = 0;

    // Carry vectors: requester, a, b, cin, expected sum, expected cout.
    logic       cv_id   [4] = '{1'b1,  1'b1,  1'b0,  1'b1};
    logic [7:0] cv_a    [4] = '{8'hFF, 8'h0F, 8'h80, 8'h7F};
    logic [7:0] cv_b    [4] = '{8'h01, 8'h01, 8'h80, 8'h00};
    logic       cv_cin  [4] = '{1'b1,  1'b0,  1'b0,  1'b1};
    logic [7:0] cv_sum  [4] = '{8'h01, 8'h10, 8'h00, 8'h80};
    logic       cv_cout [4] = '{1'b1,  1'b0,  1'b1,  1'b0};

    adder_share_arb #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_cin = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h56; req1_b = 8'h78; req1_cin = 1'b1;
        tick(); tick();
        n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0 got %b exp 0", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready1 got %b exp 0", req1_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_checks++; if (res_sum !== 8'h00) begin n_fail++; $display("FAIL rst_sum got %h exp 00", res_sum); end
        n_checks++; if (res_cout !== 1'b0) begin n_fail++; $display("FAIL rst_cout got %b exp 0", res_cout); end
        n_checks++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL rst_id got %b exp 0", res_id); end
        req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h55; req0_cin = 1'b0;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0 got %b exp 1", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready1 got %b exp 0", req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready0_exec got %b exp 0", req0_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b exp 0", res_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
        tick();
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", res_valid); end
        n_checks++; if (res_sum !== 8'h91) begin n_fail++; $display("FAIL single_sum got %h exp 91", res_sum); end
        n_checks++; if (res_cout !== 1'b0) begin n_fail++; $display("FAIL single_cout got %b exp 0", res_cout); end
        n_checks++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL single_id got %b exp 0", res_id); end
        tick();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_clear got %b exp 0", res_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b exp 0", busy); end
        n_checks++; if (res_sum !== 8'h91) begin n_fail++; $display("FAIL single_retain got %h exp 91", res_sum); end
    endtask

    task automatic test_carry();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cv_id[i]) begin
                req1_valid = 1'b1; req1_a = cv_a[i]; req1_b = cv_b[i]; req1_cin = cv_cin[i];
            end else begin
                req0_valid = 1'b1; req0_a = cv_a[i]; req0_b = cv_b[i]; req0_cin = cv_cin[i];
            end
            #1;
            n_checks++;
            if ((cv_id[i] ? req1_ready : req0_ready) !== 1'b1) begin
                n_fail++; $display("FAIL carry%0d_ready got %b%b exp granted %0d", i, req1_ready, req0_ready, cv_id[i]);
            end
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            tick();
            n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL carry%0d_valid got %b exp 1", i, res_valid); end
            n_checks++; if (res_sum !== cv_sum[i]) begin n_fail++; $display("FAIL carry%0d_sum got %h exp %h", i, res_sum, cv_sum[i]); end
            n_checks++; if (res_cout !== cv_cout[i]) begin n_fail++; $display("FAIL carry%0d_cout got %b exp %b", i, res_cout, cv_cout[i]); end
            n_checks++; if (res_id !== cv_id[i]) begin n_fail++; $display("FAIL carry%0d_id got %b exp %b", i, res_id, cv_id[i]); end
            tick();
        end
    endtask

    task automatic test_alternate();
        logic       exp_id;
        logic [7:0] exp_sum;
        rst_n = 1'b0; res_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h20; req1_cin = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id  = k[0];
            exp_sum = exp_id ? 8'h31 : 8'h03;
            n_checks++;
            if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
                n_fail++; $display("FAIL alt%0d_grant got r1r0=%b%b exp id %0d", k, req1_ready, req0_ready, exp_id);
            end
            tick();
            n_checks++; if ((req0_ready | req1_ready) !== 1'b0) begin n_fail++; $display("FAIL alt%0d_exec_ready got %b%b exp 00", k, req1_ready, req0_ready); end
            tick();
            n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL alt%0d_valid got %b exp 1", k, res_valid); end
            n_checks++; if (res_id !== exp_id) begin n_fail++; $display("FAIL alt%0d_id got %b exp %b", k, res_id, exp_id); end
            n_checks++; if (res_sum !== exp_sum) begin n_fail++; $display("FAIL alt%0d_sum got %h exp %h", k, res_sum, exp_sum); end
            n_checks++; if ((req0_ready | req1_ready) !== 1'b0) begin n_fail++; $display("FAIL alt%0d_done_ready got %b%b exp 00", k, req1_ready, req0_ready); end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55; req0_cin = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0 got %b exp 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        tick();
        // A one-cycle request from requester 1 while the result waits.
        req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22; req1_cin = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_valid got %b exp 1", i, res_valid); end
            n_checks++; if (res_sum !== 8'h00) begin n_fail++; $display("FAIL bp%0d_sum got %h exp 00", i, res_sum); end
            n_checks++; if (res_cout !== 1'b1) begin n_fail++; $display("FAIL bp%0d_cout got %b exp 1", i, res_cout); end
            n_checks++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL bp%0d_id got %b exp 0", i, res_id); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp%0d_busy got %b exp 1", i, busy); end
            n_checks++; if ((req0_ready | req1_ready) !== 1'b0) begin n_fail++; $display("FAIL bp%0d_ready got %b%b exp 00", i, req1_ready, req0_ready); end
            tick();
            req1_valid = 1'b0;
        end
        res_ready = 1'b1;
        tick();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_clear got %b exp 0", res_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %b exp 0", busy); end
        n_checks++; if (res_sum !== 8'h00 || res_cout !== 1'b1) begin n_fail++; $display("FAIL bp_retain got %h/%b exp 00/1", res_sum, res_cout); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_pulse%0d got valid %b busy %b exp 0 0", i, res_valid, busy); end
        end
    endtask

    task automatic test_reset_exec();
        res_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h01; req1_cin = 1'b0;
        #1;
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready1 got %b exp 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rx_exec_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid got %b exp 0", res_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rx_busy got %b exp 0", busy); end
        tick();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_late got %b exp 0", res_valid); end
        n_checks++; if (res_sum !== 8'h00) begin n_fail++; $display("FAIL rx_sum got %h exp 00", res_sum); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rx_tie got r1r0=%b%b exp 01", req1_ready, req0_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        test_reset();
        test_single();
        test_carry();
        test_alternate();
        test_backpressure();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
